// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: s1 registers the operation, the ALU is combinational
// from s1, and s2 holds the result plus its error bit. Registered Z/V/N flags, sticky error.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic [2:0]       flags,
  output logic             err_sticky,
  input  logic             err_clr
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int NLANE = WIDTH / LANE;
  localparam int NBYTE = WIDTH / 8;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_RED = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_PAD = 4'h7;
  localparam logic [3:0] OP_LLB = 4'h8;
  localparam logic [3:0] OP_LHB = 4'h9;

  logic             r_s1_valid;
  logic [3:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  logic             r_s2_err;
  logic [2:0]       r_flags;
  logic             r_err_sticky;

  logic             w_s1_load;
  logic             w_s1_adv;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic             w_add_ov;
  logic             w_sub_ov;
  logic [WIDTH-1:0] w_red;
  logic [WIDTH-1:0] w_padd;
  logic [LANE:0]    w_lsum;
  logic [WIDTH-1:0] w_result;
  logic             w_err;
  logic             w_wr_zn;
  logic             w_wr_v;

  // Handshake: a beat moves on a rising edge only when valid && ready; the sender
  // holds its payload while valid && !ready. in_ready depends only on registered
  // state and out_ready, never on in_valid.
  assign w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_s1_load = in_valid && in_ready;

  assign w_amt    = r_s1_b[SHW-1:0];
  assign w_sum    = r_s1_a + r_s1_b;
  assign w_dif    = r_s1_a - r_s1_b;
  assign w_add_ov = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
  assign w_sub_ov = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_s1_a[WIDTH-1]);

  always_comb begin
    w_red = '0;
    for (int i = 0; i < NBYTE; i++) begin
      w_red = w_red + WIDTH'(r_s1_a[8*i +: 8]) + WIDTH'(r_s1_b[8*i +: 8]);
    end
  end

  // Each lane is summed one bit wider; differing top two bits mean saturation.
  always_comb begin
    w_padd = '0;
    w_lsum = '0;
    for (int i = 0; i < NLANE; i++) begin
      w_lsum = {r_s1_a[i*LANE+LANE-1], r_s1_a[i*LANE +: LANE]}
             + {r_s1_b[i*LANE+LANE-1], r_s1_b[i*LANE +: LANE]};
      if (w_lsum[LANE] != w_lsum[LANE-1]) begin
        w_padd[i*LANE +: LANE] = w_lsum[LANE] ? {1'b1, {(LANE-1){1'b0}}}
                                              : {1'b0, {(LANE-1){1'b1}}};
      end else begin
        w_padd[i*LANE +: LANE] = w_lsum[LANE-1:0];
      end
    end
  end

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    w_wr_zn  = 1'b0;
    w_wr_v   = 1'b0;
    case (r_s1_op)
      OP_ADD: begin w_result = w_sum; w_err = w_add_ov; w_wr_zn = 1'b1; w_wr_v = 1'b1; end
      OP_SUB: begin w_result = w_dif; w_err = w_sub_ov; w_wr_zn = 1'b1; w_wr_v = 1'b1; end
      OP_XOR: begin w_result = r_s1_a ^ r_s1_b; w_wr_zn = 1'b1; end
      OP_RED: w_result = w_red;
      OP_SLL: begin w_result = r_s1_a << w_amt; w_wr_zn = 1'b1; end
      OP_SRA: begin w_result = $unsigned($signed(r_s1_a) >>> w_amt); w_wr_zn = 1'b1; end
      // A shift by the full width yields zero, so amount 0 returns a unchanged.
      OP_ROR: begin
        w_result = (r_s1_a >> w_amt) | (r_s1_a << (WIDTH - int'(w_amt)));
        w_wr_zn  = 1'b1;
      end
      OP_PAD: w_result = w_padd;
      OP_LLB: w_result = {r_s1_a[WIDTH-1:8], r_s1_b[7:0]};
      OP_LHB: w_result = {r_s1_b[7:0], r_s1_a[WIDTH-9:0]};
      default: begin w_result = '0; w_err = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= in_op;
        r_s1_a     <= in_a;
        r_s1_b     <= in_b;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_err    <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid  <= 1'b1;
        r_s2_result <= w_result;
        r_s2_err    <= w_err;
      end else if (out_ready) begin
        r_s2_valid  <= 1'b0;
      end
    end
  end

  // flags = {Z, V, N}; a set of err_sticky wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags      <= 3'b000;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_s1_adv && w_wr_zn) begin
        r_flags[2] <= (w_result == '0);
        r_flags[0] <= w_result[WIDTH-1];
      end
      if (w_s1_adv && w_wr_v) begin
        r_flags[1] <= w_err;
      end
      if (w_s1_adv && w_err) begin
        r_err_sticky <= 1'b1;
      end else if (err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_err    = r_s2_err;
  assign flags      = r_flags;
  assign err_sticky = r_err_sticky;

endmodule
